// File: rtl/rc_stream_loader_if.sv
// Bundles the element streams and the permutation-wrapper connection of rc_stream_loader.
// master is the loader side; slave is the upstream/downstream/wrapper environment.
interface rc_stream_loader_if #(
  parameter int unsigned STATE_SIZE = 3,
  parameter int unsigned LANES      = 13,
  parameter int unsigned N_BITS     = 254
);
  logic                                          in_valid;
  logic                                          in_ready;
  logic [N_BITS-1:0]                             in_data;
  logic                                          perm_enable;
  logic [STATE_SIZE-1:0][LANES-1:0][N_BITS-1:0]  perm_state1;
  logic [STATE_SIZE-1:0][LANES-1:0][N_BITS-1:0]  perm_state2;
  logic [STATE_SIZE-1:0][LANES-1:0][N_BITS-1:0]  perm_out1;
  logic [STATE_SIZE-1:0][LANES-1:0][N_BITS-1:0]  perm_out2;
  logic                                          perm_done;
  logic                                          out_valid;
  logic                                          out_ready;
  logic [N_BITS-1:0]                             out_data;
  logic                                          busy;

  modport master (
    input  in_valid, in_data, perm_out1, perm_out2, perm_done, out_ready,
    output in_ready, perm_enable, perm_state1, perm_state2, out_valid, out_data, busy
  );

  modport slave (
    output in_valid, in_data, perm_out1, perm_out2, perm_done, out_ready,
    input  in_ready, perm_enable, perm_state1, perm_state2, out_valid, out_data, busy
  );
endinterface

// File: rtl/rc_stream_loader.sv
// Stream adapter around the dual Reinforced Concrete permutation: loads two states element by
// element (reduced mod p), runs the wrapper until done, then streams both results back out.
module rc_stream_loader #(
  parameter int unsigned       STATE_SIZE    = 3,
  parameter int unsigned       LANES         = 13,
  parameter int unsigned       N_BITS        = 254,
  parameter logic [N_BITS-1:0] PRIME_MODULUS =
    254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001
) (
  input logic                 clk,
  input logic                 reset,
  rc_stream_loader_if.master  bus
);

  localparam int unsigned SL    = STATE_SIZE * LANES;
  localparam int unsigned TOTAL = 2 * SL;
  localparam int unsigned KW    = $clog2(TOTAL);

  typedef enum logic [2:0] {StIdle, StLoad, StRun, StCapture, StDrain} state_e;

  state_e            state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic [N_BITS-1:0] buf_q [TOTAL];
  logic [N_BITS-1:0] cap   [TOTAL];
  logic [N_BITS-1:0] reduced;
  logic              in_fire;
  logic              out_fire;
  logic              last_k;
  logic              in_ready;
  logic              perm_enable;
  logic              out_valid;

  // 2p exceeds 2^N_BITS, so one conditional subtraction fully reduces any input word.
  assign reduced  = (bus.in_data >= PRIME_MODULUS) ? bus.in_data - PRIME_MODULUS : bus.in_data;
  assign in_fire  = (state_q == StLoad) && bus.in_valid;
  assign out_fire = (state_q == StDrain) && bus.out_ready;
  assign last_k   = (k_q == KW'(TOTAL - 1));

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    in_ready    = 1'b0;
    perm_enable = 1'b0;
    out_valid   = 1'b0;
    unique case (state_q)
      StIdle: state_d = StLoad;
      StLoad: begin
        in_ready = 1'b1;
        if (in_fire) begin
          if (last_k) begin
            k_d     = '0;
            state_d = StRun;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      StRun: begin
        perm_enable = 1'b1;
        if (bus.perm_done) state_d = StCapture;
      end
      StCapture: state_d = StDrain;
      StDrain: begin
        out_valid = 1'b1;
        if (out_fire) begin
          if (last_k) begin
            k_d     = '0;
            state_d = StLoad;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  // Flat buffer: slot k = instance*SL + row*LANES + lane, shared by load, capture and drain.
  for (genvar r = 0; r < STATE_SIZE; r++) begin : g_row
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      localparam int unsigned Idx = r * LANES + l;
      assign cap[Idx]             = bus.perm_out1[r][l];
      assign cap[SL + Idx]        = bus.perm_out2[r][l];
      assign bus.perm_state1[r][l] = buf_q[Idx];
      assign bus.perm_state2[r][l] = buf_q[SL + Idx];
    end
  end

  for (genvar i = 0; i < TOTAL; i++) begin : g_slot
    always_ff @(posedge clk) begin
      if (reset) begin
        buf_q[i] <= '0;
      end else if (state_q == StCapture) begin
        buf_q[i] <= cap[i];
      end else if (in_fire && (k_q == KW'(i))) begin
        buf_q[i] <= reduced;
      end
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.perm_enable = perm_enable;
  assign bus.out_valid   = out_valid;
  assign bus.out_data    = (state_q == StDrain) ? buf_q[k_q] : '0;
  assign bus.busy        = (state_q != StIdle);

endmodule

// File: doc/rc_stream_loader.md
Name: rc_stream_loader

Overview:
- Stream adapter that sits directly upstream and downstream of the dual Reinforced Concrete permutation wrapper.
- Accepts field elements one per beat over a valid/ready stream and reduces each one mod PRIME_MODULUS.
- Packs the elements into the two state arrays, drives the wrapper's enable until it reports done, captures both output states, then streams them back out in the same order.

Parameters:
- STATE_SIZE, 3, rows per permutation state.
- LANES, 13, lanes per row (second array dimension of the wrapper state).
- N_BITS, 254, field element width.
- PRIME_MODULUS, 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001, field modulus.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  loader can accept a beat.
- in_data  in  N_BITS  input element, any value in [0, 2^N_BITS).
- perm_enable  out  1  enable to the permutation wrapper.
- perm_state1  out  [STATE_SIZE][LANES]×N_BITS  state for instance 1.
- perm_state2  out  [STATE_SIZE][LANES]×N_BITS  state for instance 2.
- perm_out1  in  [STATE_SIZE][LANES]×N_BITS  result of instance 1.
- perm_out2  in  [STATE_SIZE][LANES]×N_BITS  result of instance 2.
- perm_done  in  1  combined done from the wrapper.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  N_BITS  output element.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Definitions:
  - SL = STATE_SIZE·LANES.
  - TOTAL = 2·SL (78 at defaults).
  - Beat index k maps to instance = k / SL (0 → state1, 1 → state2), row = (k mod SL) / LANES, lane = k mod LANES.
  - The output stream uses the identical ordering.
- Reset values: in_ready=0, perm_enable=0, out_valid=0, out_data=0, busy=0, both state buffers all-zero, beat counter=0, FSM in IDLE.
- FSM states: IDLE, LOAD, RUN, CAPTURE, DRAIN.
- IDLE: go to LOAD on the next cycle. in_ready goes high in LOAD.
- LOAD:
  - in_ready=1.
  - On in_valid&in_ready, write reduce(in_data) to slot k and increment k.
  - Accepting beat TOTAL-1 clears k and moves to RUN on the next cycle.
  - A stalled input (in_valid=0) holds state indefinitely; no timeout.
- reduce(x) = x - PRIME_MODULUS if x ≥ PRIME_MODULUS, else x.
  - A single conditional subtraction is sufficient because 2·PRIME_MODULUS > 2^N_BITS.
  - Computed combinationally on in_data and registered into the buffer in the same cycle as acceptance.
- RUN:
  - perm_enable=1 continuously.
  - perm_state1/perm_state2 hold constant.
  - Stay in RUN until perm_done is sampled 1.
  - perm_done sampled high in the first RUN cycle is still honoured.
- CAPTURE (1 cycle):
  - Register perm_out1/perm_out2 into the same buffers, overwriting the inputs.
  - perm_enable drops to 0 in this cycle.
  - Go to DRAIN.
- DRAIN:
  - out_valid=1 and out_data = buffer slot k.
  - On out_valid&out_ready, increment k.
  - out_data and out_valid hold stable while out_ready=0.
  - Completing beat TOTAL-1 clears k and returns to LOAD on the next cycle (out_valid=0 that cycle).
  - No bypass; in_ready=0 throughout DRAIN.
- Latency:
  - First output beat is valid exactly 2 cycles after the cycle perm_done is sampled high: CAPTURE, then DRAIN.
  - A full job takes TOTAL + 1 + permutation cycles + 1 + TOTAL cycles at full throughput.
- perm_state1/perm_state2 are driven directly from the buffers at all times. They are meaningful only while perm_enable=1.
- perm_done outside RUN is ignored.
- Reset asserted in any state:
  - Next cycle matches the reset values.
  - In-flight data is discarded.
  - perm_enable deasserts, and no partial output is emitted.

Test Plan:
- Single job: feed k = 0..77 as in_data, stub permutation returns each input+1 with perm_done 5 cycles after enable → out stream 1..78 in order, first out_valid 2 cycles after perm_done, perm_enable high exactly through RUN.
- Reduction: in_data = PRIME_MODULUS, PRIME_MODULUS+7, 2^254-1, PRIME_MODULUS-1 → buffered values 0, 7, 2^254-1-PRIME_MODULUS, PRIME_MODULUS-1.
  - Check perm_state1[0][0..3] with the identity stub.
- Mapping: beat 13 → perm_state1[1][0]; beat 38 → perm_state1[2][12]; beat 39 → perm_state2[0][0]; beat 77 → perm_state2[2][12].
- Backpressure: in_valid toggles 1,0,1,0 and out_ready random 50% → no lost or duplicated beats, out_data stable while stalled, 78 beats each way.
- Immediate done: perm_done tied high → RUN lasts 1 cycle, outputs still correct; perm_done pulses during LOAD/DRAIN are ignored.
- Reset mid-job:
  - Assert reset at beat 40 of LOAD → next cycle in_ready=0, busy=0, buffers zero.
  - Assert reset during DRAIN at beat 10 → out_valid=0 next cycle.
  - A fresh 78-beat job afterwards completes correctly.
